// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared types and constants for the run controller.
// Holds the FSM state encoding, halt cause codes, the system instruction
// encodings and the mask of opcode bits that must be set on a valid 32-bit instruction.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_ECALL   = 3'd2;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd3;
  localparam logic [2:0] CAUSE_LOOP    = 3'd4;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd5;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
  localparam logic [31:0] ECALL_INSN  = 32'h0000_0073;

  // Low opcode bits of every 32-bit (non-compressed) encoding are 2'b11.
  localparam logic [1:0] OPC_VALID_MASK = 2'b11;

endpackage

// File: rtl/run_monitor_halt_detect.sv
// halt_detect: combinational priority encoder for run-stop conditions.
// Ports: instruction/pc_eq/loop_cnt/timeout in; halt flag and 3-bit cause out.
// Priority: ebreak > ecall > illegal > self-loop > timeout.
module halt_detect
  import run_monitor_pkg::*;
#(
  parameter int unsigned LOOP_LIMIT = 4,
  parameter int unsigned LCW        = 3
) (
  input  logic [31:0]    instruction,
  input  logic           pc_eq,
  input  logic [LCW-1:0] loop_cnt,
  input  logic           timeout,
  output logic           halt,
  output logic [2:0]     cause
);

  logic illegal;
  logic loop_hit;

  assign illegal  = ((instruction[1:0] & OPC_VALID_MASK) != OPC_VALID_MASK) ||
                    (instruction == 32'd0);
  // The counter value after this cycle's compare is loop_cnt+1 when pc repeats.
  assign loop_hit = pc_eq && ((32'(loop_cnt) + 32'd1) >= LOOP_LIMIT);

  always_comb begin
    halt  = 1'b1;
    cause = CAUSE_NONE;
    if (instruction == EBREAK_INSN)     cause = CAUSE_EBREAK;
    else if (instruction == ECALL_INSN) cause = CAUSE_ECALL;
    else if (illegal)                   cause = CAUSE_ILLEGAL;
    else if (loop_hit)                  cause = CAUSE_LOOP;
    else if (timeout)                   cause = CAUSE_TIMEOUT;
    else                                halt  = 1'b0;
  end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: run controller gating a single-cycle core, stopping on
// ebreak/ecall/illegal/self-loop/timeout and reporting cause and counters.
// Ports: clk, rst, start, pc, instruction in; run_en, done, halt_cause, cycle_count, last_pc out.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned CYCLE_WIDTH  = 32,
  parameter int unsigned MAX_CYCLES   = 50,
  parameter int unsigned LOOP_LIMIT   = 4,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [XLEN-1:0]        pc,
  input  logic [31:0]            instruction,
  output logic                   run_en,
  output logic                   done,
  output logic [2:0]             halt_cause,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic [XLEN-1:0]        last_pc
);

  localparam int unsigned LCW = $clog2(LOOP_LIMIT + 1);
  localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  // A MAX_CYCLES that does not fit in the counter can never be reached.
  localparam bit TO_EN = (MAX_CYCLES != 0) &&
                         ((64'(MAX_CYCLES) >> CYCLE_WIDTH) == 64'd0);
  localparam logic [CYCLE_WIDTH-1:0] TO_VAL = CYCLE_WIDTH'(MAX_CYCLES);

  state_t               state;
  logic [LCW-1:0]       loop_cnt;
  logic [DCW-1:0]       drain_cnt;
  logic                 first_cyc;   // last_pc is stale on the first RUN cycle

  logic                   pc_eq;
  logic [LCW-1:0]         loop_next;
  logic [CYCLE_WIDTH-1:0] cycle_inc;
  logic                   timeout;
  logic                   halt;
  logic [2:0]             cause;

  assign pc_eq     = !first_cyc && (pc == last_pc);
  assign loop_next = pc_eq ? loop_cnt + LCW'(1) : '0;
  assign cycle_inc = cycle_count + CYCLE_WIDTH'(1);
  assign timeout   = TO_EN && (cycle_inc == TO_VAL);

  halt_detect #(
    .LOOP_LIMIT (LOOP_LIMIT),
    .LCW        (LCW)
  ) u_halt_detect (
    .instruction (instruction),
    .pc_eq       (pc_eq),
    .loop_cnt    (loop_cnt),
    .timeout     (timeout),
    .halt        (halt),
    .cause       (cause)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      run_en      <= 1'b0;
      done        <= 1'b0;
      halt_cause  <= CAUSE_NONE;
      cycle_count <= '0;
      last_pc     <= '0;
      loop_cnt    <= '0;
      drain_cnt   <= '0;
      first_cyc   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RUN;
            run_en      <= 1'b1;
            done        <= 1'b0;
            halt_cause  <= CAUSE_NONE;
            cycle_count <= '0;
            loop_cnt    <= '0;
            drain_cnt   <= '0;
            first_cyc   <= 1'b1;
          end
        end
        S_RUN: begin
          // The halting cycle itself is counted and its pc recorded.
          cycle_count <= (&cycle_count) ? cycle_count : cycle_inc;
          last_pc     <= pc;
          loop_cnt    <= loop_next;
          first_cyc   <= 1'b0;
          if (halt) begin
            halt_cause <= cause;
            run_en     <= 1'b0;
            drain_cnt  <= '0;
            if (DRAIN_CYCLES == 0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: scoreboard bench for run_monitor with default parameters.
// A behavioural "core" supplies pc/instruction per RUN cycle; expected halt
// results are queued at start and compared when done rises.
module tb_run_monitor;

  localparam logic [63:0] PC0  = 64'h1000;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] JAL0 = 32'h0000_006F;

  typedef struct packed {
    logic [2:0]  cause;
    logic [31:0] cnt;
    logic [63:0] lpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic        run_en;
  logic        done;
  logic [2:0]  halt_cause;
  logic [31:0] cycle_count;
  logic [63:0] last_pc;

  int vectors     = 0;
  int miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  run_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc          (pc),
    .instruction (instruction),
    .run_en      (run_en),
    .done        (done),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count),
    .last_pc     (last_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_run_en"}, 64'(run_en), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_cause"}, 64'(halt_cause), 64'd0);
    check({tag, "_cnt"}, 64'(cycle_count), 64'd0);
    check({tag, "_lpc"}, last_pc, 64'd0);
  endtask

  function automatic exp_t expect_for(input int scn);
    exp_t e;
    case (scn)
      0:       e = '{3'd1, 32'd10, PC0 + 64'd36};
      1:       e = '{3'd5, 32'd50, PC0 + 64'd196};
      2:       e = '{3'd4, 32'd9,  64'h40};
      3:       e = '{3'd2, 32'd50, PC0 + 64'd196};
      4:       e = '{3'd3, 32'd1,  PC0};
      default: e = '{3'd3, 32'd3,  PC0 + 64'd8};
    endcase
    return e;
  endfunction

  // Stimulus of RUN cycle k (1-based) for each scenario.
  task automatic drive(input int scn, input int k);
    pc          = PC0 + 64'(4 * (k - 1));
    instruction = ADDI;
    case (scn)
      0: if (k == 10) instruction = 32'h0010_0073;
      2: if (k >= 5) begin pc = 64'h40; instruction = JAL0; end
      3: if (k == 50) instruction = 32'h0000_0073;
      4: if (k == 1) instruction = 32'h0;
      5: if (k == 3) instruction = 32'h0010_0092;
      default: ;
    endcase
  endtask

  task automatic run_scn(input int scn, input bit drain_rst);
    exp_t e;
    int   k;
    int   d;
    bit   halted;
    if (!drain_rst) sb.push_back(expect_for(scn));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_run_en", 64'(run_en), 64'd1);
    check("start_done", 64'(done), 64'd0);
    check("start_cnt", 64'(cycle_count), 64'd0);
    check("start_cause", 64'(halt_cause), 64'd0);
    k = 1;
    halted = 1'b0;
    while (!halted && k <= 200) begin
      drive(scn, k);
      // A start pulse mid-run must be ignored.
      start = (scn == 1 && k == 20);
      @(negedge clk);
      start = 1'b0;
      if (!run_en) halted = 1'b1;
      else k++;
    end
    if (!halted) begin
      check("halt_seen", 64'd0, 64'd1);
      return;
    end
    check("halt_not_done_yet", 64'(done), 64'd0);
    if (drain_rst) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("drain_rst");
      @(negedge clk);
      check_idle("drain_rst_hold");
      return;
    end
    d = 0;
    while (!done && d < 20) begin
      @(negedge clk);
      d++;
    end
    check("drain_len", 64'(d), 64'd2);
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check("cause", 64'(halt_cause), 64'(e.cause));
    check("cycle_count", 64'(cycle_count), 64'(e.cnt));
    check("last_pc", last_pc, e.lpc);
    check("run_en_off", 64'(run_en), 64'd0);
    @(negedge clk);
    check("done_sticky", 64'(done), 64'd1);
    check("cause_hold", 64'(halt_cause), 64'(e.cause));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    pc          = '0;
    instruction = ADDI;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_run_en", 64'(run_en), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_cnt", 64'(cycle_count), 64'd0);
    end
    run_scn(0, 1'b0);   // ebreak on cycle 10
    run_scn(1, 1'b0);   // timeout at 50, stray start ignored
    run_scn(2, 1'b0);   // self-loop at pc 0x40
    run_scn(3, 1'b0);   // ecall on cycle 50 beats timeout
    run_scn(5, 1'b0);   // restart from DONE, illegal low opcode bits
    run_scn(0, 1'b1);   // reset while draining
    run_scn(4, 1'b0);   // all-zero instruction on first cycle
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
Parametrised simulation/run controller that supersedes the fixed 50-cycle stop logic around the single-cycle RV64 core. It gates the core with run_en, counts cycles and watches the fetched pc/instruction each cycle. It stops the run on ebreak, ecall, illegal encoding, a self-loop or a programmable timeout, then reports the cause and counters. The bench instantiates it beside core and program_memory and calls $finish on done.

Parameters:
XLEN, 64, width of pc and last_pc
CYCLE_WIDTH, 32, width of cycle_count
MAX_CYCLES, 50, timeout in RUN cycles; 0 disables timeout
LOOP_LIMIT, 4, consecutive RUN cycles with pc equal to the previous pc that declare a self-loop (min 1)
DRAIN_CYCLES, 2, cycles spent in DRAIN before done (0 allowed)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse that begins or restarts a run
pc  input  XLEN  current core pc
instruction  input  32  instruction fetched at pc
run_en  output  1  registered; high only in RUN; drives the core enable
done  output  1  high in DONE; sticky
halt_cause  output  3  0 none, 1 ebreak, 2 ecall, 3 illegal, 4 loop, 5 timeout
cycle_count  output  CYCLE_WIDTH  RUN cycles elapsed, saturating
last_pc  output  XLEN  pc sampled on the last RUN cycle

Behaviour:
- Reset is synchronous and active-high: state<=IDLE; run_en, done, halt_cause, cycle_count, last_pc, loop counter and drain counter all 0. Reset has priority over every other event in every state, including mid-run and mid-DRAIN.
- States are IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN on the next edge; counters cleared, run_en<=1.
- RUN, on every edge:
  - cycle_count++ (saturates at all-ones).
  - last_pc<=pc.
  - loop counter: +1 if pc==last_pc, else cleared. No compare on the first RUN cycle after entry, since last_pc is stale.
- Halt detection in RUN, evaluated on the current instruction/pc, in fixed priority:
  - ebreak (32'h00100073)
  - ecall (32'h00000073)
  - illegal: instruction[1:0]!=2'b11, or instruction==0
  - loop: loop counter reaching LOOP_LIMIT on this cycle
  - timeout: MAX_CYCLES!=0 and cycle_count+1==MAX_CYCLES
- On a detect edge: halt_cause latched, run_en<=0, state<=DRAIN (or DONE if DRAIN_CYCLES==0). The halting cycle is included in cycle_count.
- start while in RUN or DRAIN is ignored.
- DRAIN: drain counter counts DRAIN_CYCLES edges, then DONE. run_en stays 0; cycle_count and last_pc are frozen.
- DONE: done=1; all outputs hold.
  - start=1 -> RUN with counters and halt_cause cleared, done<=0.
  - rst -> IDLE.
- Latency: halting instruction presented in cycle N -> run_en low after edge N; done high after edge N+DRAIN_CYCLES (edge N if DRAIN_CYCLES==0).
- Widths: comparisons of cycle_count with MAX_CYCLES are done at CYCLE_WIDTH. If MAX_CYCLES exceeds 2^CYCLE_WIDTH-1, the timeout never fires and the counter saturates.

Decomposition:
- Shared package run_monitor_pkg holds:
  - state enum
  - halt_cause codes
  - EBREAK/ECALL encoding constants
  - opcode-valid mask
- Sub-module halt_detect: combinational priority encoder taking instruction, the pc-equal flag, the loop counter and the timeout flag, and producing halt/cause. It is reused by a future pipelined-core monitor.
- The FSM, counters and registers stay in run_monitor.

Test Plan:
- rst held 3 cycles, then released with no start -> state IDLE, run_en=0, done=0, cycle_count=0 indefinitely.
- start pulse, then ADDI stream (32'h00100093) with pc +4 each cycle, ebreak presented on RUN cycle 10 -> halt_cause=1, cycle_count=10, run_en low after that edge, done 2 cycles later.
- Same stream with no halting instruction, MAX_CYCLES=50 -> halt_cause=5, cycle_count=50, last_pc=pc of cycle 50.
- pc fixed at 64'h40 with jal x0,0 (32'h0000006F) from RUN cycle 5, LOOP_LIMIT=4 -> halt_cause=4 on cycle 9, last_pc=64'h40.
- ecall on exactly cycle 50 with MAX_CYCLES=50 -> halt_cause=2 (priority over timeout). Then start in DONE -> RUN, cycle_count=0, done=0.
- rst asserted during DRAIN -> IDLE next edge, all outputs 0. instruction=0 on the first RUN cycle -> halt_cause=3, cycle_count=1.
